// File: rtl/viexo_fb_arbiter.sv
// rtl/viexo_fb_arbiter.sv - framebuffer port arbiter and scan-out sequencer
// Even active columns own the RAM for scan-out; every other slot serves the writer.
module viexo_fb_arbiter #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int ADDR_W   = 18
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic [11:0]       x,
   input  logic [11:0]       y,
   input  logic              hblank,
   input  logic              vblank,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [15:0]       wr_data,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic [15:0]       mem_rdata,
   output logic              pix_valid,
   output logic [7:0]        pix_data,
   output logic              pix_hblank,
   output logic              pix_vblank,
   output logic              wr_oob
);

   localparam int HALF_W = H_ACTIVE / 2;
   localparam int WORDS  = HALF_W * V_ACTIVE;

   typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} state_t;

   logic              w_active;
   logic              w_read_slot;
   logic              w_wr_slot;
   logic              w_wr_in_range;
   logic              w_do_read;
   logic              w_do_write;
   logic [ADDR_W-1:0] w_rd_addr;

   state_t            r_state;
   logic              r_rd_pend;
   logic [7:0]        r_hi_hold;
   logic [7:0]        r_pix_data;
   logic              r_pix_valid;
   logic [1:0]        r_hb;
   logic [1:0]        r_vb;
   logic              r_oob;

   assign w_active      = (32'(x) < 32'(H_ACTIVE)) && (32'(y) < 32'(V_ACTIVE));
   assign w_read_slot   = w_active && !x[0];
   assign w_wr_slot     = !w_read_slot;
   assign w_wr_in_range = 32'(wr_addr) < 32'(WORDS);
   assign w_rd_addr     = ADDR_W'(y) * ADDR_W'(HALF_W) + ADDR_W'(x[11:1]);

   // Command path is gated by reset so a held reset keeps the RAM quiet.
   assign w_do_read  = aresetn && w_read_slot;
   assign w_do_write = aresetn && w_wr_slot && wr_valid && w_wr_in_range;

   assign wr_ready  = aresetn && w_wr_slot;
   assign mem_en    = w_do_read || w_do_write;
   assign mem_we    = w_do_write;
   assign mem_addr  = w_do_read  ? w_rd_addr :
                      w_do_write ? wr_addr   : '0;
   assign mem_wdata = w_do_write ? wr_data : 16'h0000;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_rd_pend <= 1'b0;
         r_hb      <= 2'b00;
         r_vb      <= 2'b00;
         r_oob     <= 1'b0;
      end else begin
         r_rd_pend <= w_read_slot;
         r_hb      <= {r_hb[0], hblank};
         r_vb      <= {r_vb[0], vblank};
         if (wr_valid && w_wr_slot && !w_wr_in_range)
            r_oob <= 1'b1;
      end
   end

   // mem_rdata is consumed directly on the cycle rd_pend is high.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state     <= S_IDLE;
         r_pix_valid <= 1'b0;
         r_pix_data  <= 8'h00;
         r_hi_hold   <= 8'h00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_rd_pend) begin
                  r_state     <= S_LO;
                  r_pix_data  <= mem_rdata[7:0];
                  r_hi_hold   <= mem_rdata[15:8];
                  r_pix_valid <= 1'b1;
               end else begin
                  r_pix_valid <= 1'b0;
               end
            end
            S_LO: begin
               r_state     <= S_HI;
               r_pix_data  <= r_hi_hold;
               r_pix_valid <= 1'b1;
            end
            S_HI: begin
               if (r_rd_pend) begin
                  r_state     <= S_LO;
                  r_pix_data  <= mem_rdata[7:0];
                  r_hi_hold   <= mem_rdata[15:8];
                  r_pix_valid <= 1'b1;
               end else begin
                  r_state     <= S_IDLE;
                  r_pix_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_pix_valid <= 1'b0;
            end
         endcase
      end
   end

   assign pix_valid  = r_pix_valid;
   assign pix_data   = r_pix_data;
   assign pix_hblank = r_hb[1];
   assign pix_vblank = r_vb[1];
   assign wr_oob     = r_oob;

endmodule

// File: tb/tb_viexo_fb_arbiter.sv
// tb/tb_viexo_fb_arbiter.sv - scoreboard bench for viexo_fb_arbiter
// Driver pushes expected pixels and RAM writes; a negedge monitor pops and compares.
module tb_viexo_fb_arbiter;

   localparam int H  = 640;
   localparam int V  = 480;
   localparam int AW = 18;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic [11:0]   x, y;
   logic          hblank, vblank;
   logic          wr_valid;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;
   logic [15:0]   wr_data;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_wdata;
   logic [15:0]   mem_rdata = 16'h0000;
   logic          pix_valid;
   logic [7:0]    pix_data;
   logic          pix_hblank, pix_vblank, wr_oob;

   int            n_assert = 0;
   int            n_fail   = 0;
   logic [7:0]    exp_pix[$];
   logic [33:0]   exp_wr[$];
   logic [15:0]   shadow[int];
   logic [15:0]   ram [0:8191] = '{default: 16'h0000};
   logic [7:0]    mon_pe;
   logic [33:0]   mon_we;

   always #5 aclk = ~aclk;

   viexo_fb_arbiter #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
      .aclk(aclk), .aresetn(aresetn), .x(x), .y(y), .hblank(hblank), .vblank(vblank),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .pix_valid(pix_valid), .pix_data(pix_data),
      .pix_hblank(pix_hblank), .pix_vblank(pix_vblank), .wr_oob(wr_oob)
   );

   // Single-port RAM with one cycle read latency.
   always @(posedge aclk) begin
      if (mem_en === 1'b1) begin
         if (mem_we === 1'b1) begin
            if (mem_addr < 18'd8192) ram[mem_addr[12:0]] <= mem_wdata;
         end else begin
            mem_rdata <= ram[mem_addr[12:0]];
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_assert++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic logic [15:0] sh(input int a);
      if (shadow.exists(a)) return shadow[a];
      return 16'h0000;
   endfunction

   always @(negedge aclk) begin
      if (pix_valid === 1'b1) begin
         if (exp_pix.size() == 0) begin
            chk("pix_unexpected", 32'(pix_data), 32'hFFFF_FFFF);
         end else begin
            mon_pe = exp_pix.pop_front();
            chk("pix_data", 32'(pix_data), 32'(mon_pe));
         end
      end
      if (mem_en === 1'b1 && mem_we === 1'b1) begin
         if (exp_wr.size() == 0) begin
            chk("wr_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
         end else begin
            mon_we = exp_wr.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(mon_we[33:16]));
            chk("wr_data", 32'(mem_wdata), 32'(mon_we[15:0]));
         end
      end
   end

   task automatic drive(input logic rn, input int xv, input int yv, input logic wv,
                        input int wa, input logic [15:0] wd);
      logic [15:0] w;
      @(posedge aclk);
      #1;
      if (!rn && aresetn) exp_pix.delete();
      aresetn  = rn;
      x        = 12'(xv);
      y        = 12'(yv);
      hblank   = (xv >= H);
      vblank   = (yv >= V);
      wr_valid = wv;
      wr_addr  = AW'(wa);
      wr_data  = wd;
      if (rn && xv < H && yv < V && (xv % 2) == 0) begin
         w = sh(yv * (H / 2) + xv / 2);
         exp_pix.push_back(w[7:0]);
         exp_pix.push_back(w[15:8]);
      end
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int pa [5];
      logic [15:0] pd [5];
      int vcnt, idx, acc_act, acc_all;
      logic pushed;
      pa = '{0, 1, 2, 3, 4};
      pd = '{16'h2211, 16'hBBAA, 16'hDDCC, 16'h4433, 16'h6655};
      aresetn = 1'b0; x = '0; y = '0; hblank = 1'b0; vblank = 1'b0;
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      repeat (2) @(negedge aclk);

      // Reset state while x=0,y=0 would be a READ slot
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdata", 32'(mem_wdata), 0);
      chk("rst_wr_ready", 32'(wr_ready), 0);
      chk("rst_pix_valid", 32'(pix_valid), 0);
      chk("rst_pix_data", 32'(pix_data), 0);
      chk("rst_pix_hblank", 32'(pix_hblank), 0);
      chk("rst_pix_vblank", 32'(pix_vblank), 0);
      chk("rst_wr_oob", 32'(wr_oob), 0);

      for (int i = 0; i < 4; i++) begin
         drive(1'b1, i, 490, 1'b0, 0, 16'h0);
         @(negedge aclk);
         chk("idle_mem_en", 32'(mem_en), 0);
         chk("idle_pix_valid", 32'(pix_valid), 0);
         chk("blank_wr_ready", 32'(wr_ready), 1);
      end

      // Vertical blank: one write per cycle
      for (int i = 0; i < 5; i++) begin
         shadow[pa[i]] = pd[i];
         drive(1'b1, 4 + i, 490, 1'b1, pa[i], pd[i]);
         exp_wr.push_back({AW'(pa[i]), pd[i]});
         @(negedge aclk);
         chk("vb_wr_ready", 32'(wr_ready), 1);
         chk("vb_mem_en", 32'(mem_en), 1);
         chk("vb_mem_we", 32'(mem_we), 1);
         chk("vb_pix_valid", 32'(pix_valid), 0);
         if (i == 2) chk("vb_pix_vblank", 32'(pix_vblank), 1);
      end
      drive(1'b1, 9, 490, 1'b0, 0, 16'h0);
      @(negedge aclk);

      // Line 0 scan-out of the preloaded words
      vcnt = 0;
      for (int xi = 0; xi < 800; xi++) begin
         drive(1'b1, xi, 0, 1'b0, 0, 16'h0);
         @(negedge aclk);
         if (pix_valid === 1'b1) vcnt++;
         if (mem_we !== 1'b0) chk("l0_mem_we", 32'(mem_we), 0);
         case (xi)
            1: begin
               chk("l0_x1_valid", 32'(pix_valid), 0);
               chk("l0_x1_vblank", 32'(pix_vblank), 1);
            end
            2: begin
               chk("l0_x2_valid", 32'(pix_valid), 1);
               chk("l0_x2_vblank", 32'(pix_vblank), 0);
            end
            4: begin
               chk("l0_x4_pix", 32'(pix_data), 32'h0000_00AA);
               chk("l0_x4_addr", 32'(mem_addr), 2);
            end
            641: begin
               chk("l0_x641_valid", 32'(pix_valid), 1);
               chk("l0_x641_hblank", 32'(pix_hblank), 0);
            end
            642: begin
               chk("l0_x642_valid", 32'(pix_valid), 0);
               chk("l0_x642_hblank", 32'(pix_hblank), 1);
            end
            default: ;
         endcase
      end
      chk("l0_valid_count", 32'(vcnt), 640);

      // Line 5 with the writer permanently valid
      idx = 0; acc_act = 0; acc_all = 0; pushed = 1'b0;
      for (int xi = 0; xi < 800; xi++) begin
         drive(1'b1, xi, 5, 1'b1, 6000 + idx, 16'h5000 + 16'(idx));
         if (!pushed) begin
            exp_wr.push_back({AW'(6000 + idx), 16'h5000 + 16'(idx)});
            pushed = 1'b1;
         end
         @(negedge aclk);
         if (xi < H) begin
            chk("l5_wr_ready", 32'(wr_ready), 32'(xi % 2));
            chk("l5_mem_we", 32'(mem_we), 32'(xi % 2));
         end else begin
            chk("l5_blank_ready", 32'(wr_ready), 1);
         end
         if (xi == 6) begin
            chk("l5_rd_addr", 32'(mem_addr), 1603);
            chk("l5_rd_en", 32'(mem_en), 1);
         end
         if (wr_ready === 1'b1) begin
            shadow[6000 + idx] = 16'h5000 + 16'(idx);
            idx++; acc_all++;
            if (xi < H) acc_act++;
            pushed = 1'b0;
         end
      end
      chk("l5_active_accepts", 32'(acc_act), 320);
      chk("l5_total_accepts", 32'(acc_all), 480);

      // Out-of-range and last-valid writer addresses
      drive(1'b1, 700, 20, 1'b0, 0, 16'h0);
      @(negedge aclk);
      chk("oob_pre", 32'(wr_oob), 0);
      drive(1'b1, 3, 20, 1'b1, 153600, 16'h1234);
      @(negedge aclk);
      chk("oob_wr_ready", 32'(wr_ready), 1);
      chk("oob_mem_en", 32'(mem_en), 0);
      chk("oob_not_yet", 32'(wr_oob), 0);
      drive(1'b1, 5, 20, 1'b1, 153599, 16'hA5A5);
      exp_wr.push_back({AW'(153599), 16'hA5A5});
      @(negedge aclk);
      chk("last_addr_en", 32'(mem_en), 1);
      chk("last_addr_we", 32'(mem_we), 1);
      chk("oob_set", 32'(wr_oob), 1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 702 + i, 20, 1'b0, 0, 16'h0);
         @(negedge aclk);
         chk("oob_sticky", 32'(wr_oob), 1);
      end

      // Line 10 with reset pulsed at x=101..103
      for (int xi = 0; xi < 800; xi++) begin
         drive((xi < 101 || xi > 103), xi, 10, 1'b0, 0, 16'h0);
         @(negedge aclk);
         if (xi == 50) chk("l10_oob_held", 32'(wr_oob), 1);
         if (xi >= 101 && xi <= 103) begin
            chk("mrst_pix_valid", 32'(pix_valid), 0);
            chk("mrst_wr_ready", 32'(wr_ready), 0);
            chk("mrst_mem_en", 32'(mem_en), 0);
            chk("mrst_wr_oob", 32'(wr_oob), 0);
         end
         if (xi == 105) chk("mrst_x105_valid", 32'(pix_valid), 0);
         if (xi == 106) chk("mrst_x106_valid", 32'(pix_valid), 1);
      end

      for (int i = 0; i < 10; i++) begin
         drive(1'b1, i, 490, 1'b0, 0, 16'h0);
         @(negedge aclk);
      end
      chk("pix_queue_drained", 32'(exp_pix.size()), 0);
      chk("wr_queue_drained", 32'(exp_wr.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/viexo_fb_arbiter.md
# viexo_fb_arbiter

Framebuffer port arbiter and scan-out sequencer for the display path. It sits between the pixel timing generator, which supplies x, y, hblank and vblank, and a single-port synchronous framebuffer RAM. The RAM stores 16-bit words, each holding two 8-bit pixels. The block schedules one scan-out read per pixel pair during the active region, gives every other RAM slot to a writer port with a valid/ready handshake, and serialises fetched words into one pixel per clock.

## Interface
- H_ACTIVE, 640: active pixels per line; must be even.
- V_ACTIVE, 480: active lines per frame.
- ADDR_W, 18: RAM word address width; must hold H_ACTIVE/2*V_ACTIVE words.
- aclk  in  1  sole clock.
- aresetn  in  1  reset, asynchronous, active-low.
- x  in  12  current pixel column from the timing generator (unsigned).
- y  in  12  current line from the timing generator (unsigned).
- hblank  in  1  horizontal blank flag; passed through to the output delay line.
- vblank  in  1  vertical blank flag; passed through to the output delay line.
- wr_valid  in  1  writer has a word to store.
- wr_ready  out  1  writer word accepted this cycle when high together with wr_valid.
- wr_addr  in  ADDR_W  writer word address.
- wr_data  in  16  writer word; [7:0] is the even pixel, [15:8] the odd pixel.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable; only meaningful when mem_en is high.
- mem_addr  out  ADDR_W  RAM word address.
- mem_wdata  out  16  RAM write data.
- mem_rdata  in  16  RAM read data, valid exactly 1 cycle after a read strobe.
- pix_valid  out  1  pix_data carries an active pixel.
- pix_data  out  8  scan-out pixel.
- pix_hblank  out  1  hblank delayed 2 cycles.
- pix_vblank  out  1  vblank delayed 2 cycles.
- wr_oob  out  1  sticky flag: a writer address was out of range.

## Operation
- Active region: x < H_ACTIVE and y < V_ACTIVE. Everything outside it counts as blanking, regardless of hblank and vblank.
- Slot classification is combinational from x and y each cycle:
  - READ: active region and x[0]=0.
  - FREE: active region and x[0]=1.
  - BLANK: outside the active region.
- READ slot:
  - mem_en=1, mem_we=0.
  - mem_addr = y*(H_ACTIVE/2) + x[11:1], truncated to ADDR_W.
  - wr_ready=0.
- FREE or BLANK slot:
  - wr_ready=1.
  - If wr_valid and wr_addr < H_ACTIVE/2*V_ACTIVE: mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
  - If wr_valid and the address is out of range: the word is accepted and dropped (mem_en=0), and wr_oob sets.
  - If wr_valid=0: mem_en=0.
- Writer rule: wr_addr and wr_data must stay stable while wr_valid=1 and wr_ready=0. The writer must not drop wr_valid before it is accepted.
- Scan-out FSM has 3 states:
  - IDLE: go to LO when rd_pend=1.
  - LO: pix_data<=mem_rdata[7:0], hi_hold<=mem_rdata[15:8], pix_valid<=1. Always go to HI.
  - HI: pix_data<=hi_hold, pix_valid<=1. Go to LO if rd_pend=1, otherwise to IDLE.
  - rd_pend is a register set to 1 on the cycle after every READ slot.
- The transition into IDLE sets pix_valid<=0 and holds pix_data.
- wr_oob clears only on reset.
- Reset values:
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - wr_ready=0, pix_valid=0, pix_data=0, hi_hold=0.
  - pix_hblank=0, pix_vblank=0, wr_oob=0, rd_pend=0, FSM=IDLE.
- Reset mid-line: everything returns to its reset value asynchronously. Scan-out resumes at the next READ slot, with no pixel emitted from a stale read.

## Timing
- Memory command outputs are combinational from x, y and the writer inputs, with zero-cycle decision latency. wr_ready is combinational from x and y only.
- Scan-out latency: the pixel for column x appears on pix_data exactly 2 cycles after that x is presented.
- Pixel pair pipeline:
  - Cycle t: READ slot for columns 2k and 2k+1.
  - Cycle t+1: mem_rdata valid; FIFO-free FREE slot.
  - Cycle t+2: pixel 2k on pix_data.
  - Cycle t+3: pixel 2k+1 on pix_data.
- Within one line, pix_valid is high continuously for H_ACTIVE cycles, starting 2 cycles after x=0.
- The last READ of a line is at x=H_ACTIVE-2; its pixels appear at x=H_ACTIVE and x=H_ACTIVE+1.
- pix_hblank and pix_vblank are delayed 2 cycles so they align with pix_data.
- Writer throughput:
  - Active region: 1 word per 2 cycles.
  - Blanking: 1 word per cycle.
- Simultaneous READ slot and wr_valid: the read always wins, and the write waits for the next slot.
- If x or y jumps (the generator wraps or resets): slot classification follows the new value immediately. Any fetch already in flight still completes its LO/HI output.

## Test plan
- Reset release, no writer activity -> mem_we never asserts; pix_valid stays 0 until 2 cycles after the first READ slot at x=0, y=0.
- Preload word 0x BBAA at address 1 and 0x DDCC at address 2, drive y=0 and x=0,1,2,3... -> pix_data in cycles 4..7 is AA, BB, CC, DD; pix_valid stays high for all 640 pixels.
- Hold wr_valid=1 through active line y=5 -> wr_ready high only on odd x; 320 writes accepted on that line; no write ever lands on an even-x cycle.
- Hold wr_valid=1 during y=490 -> one write accepted per cycle; mem_en=1 every cycle; pix_valid=0.
- wr_addr=153600 in a FREE slot -> wr_ready=1, mem_en=0, wr_oob latches to 1 and holds until aresetn is asserted.
- Assert aresetn low at x=101, y=10 for 3 cycles -> pix_valid=0, wr_ready=0, FSM in IDLE; after release, the first valid pixel appears 2 cycles after the next even active x.
